// File: rtl/exp3_fluxo_dados.sv
// exp3_fluxo_dados -- datapath for the experiment-3 control unit.
// Position counter, player-entry register, fixed 16-entry expected-value ROM,
// comparator, entry-edge detector and board debug outputs.
// Optional build macro FLUXO_TENTATIVAS_EN adds a saturating count of register
// loads on db_tentativas; without it db_tentativas is held at zero.
module exp3_fluxo_dados #(
   parameter int N_DADOS = 4,
   parameter int N_END   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               zeraC,
   input  logic               contaC,
   input  logic               zeraR,
   input  logic               registraR,
   input  logic [N_DADOS-1:0] chaves,
   output logic               fimC,
   output logic               resultado,
   output logic               jogada_feita,
   output logic [N_END-1:0]   db_contagem,
   output logic [N_DADOS-1:0] db_memoria,
   output logic [N_DADOS-1:0] db_chaves,
   output logic [3:0]         db_tentativas
);

   logic [N_END-1:0]   contagem;
   logic [N_DADOS-1:0] registro;
   logic [N_DADOS-1:0] memoria;
   logic               chaves_ant;
   logic               chaves_ativas;

   // Position counter: reset > zeraC > contaC, wraps naturally at the top address.
   always_ff @(posedge clock) begin
      if (reset)
         contagem <= '0;
      else if (zeraC)
         contagem <= '0;
      else if (contaC)
         contagem <= contagem + N_END'(1);
   end

   // Entry register: reset > zeraR > registraR.
   always_ff @(posedge clock) begin
      if (reset)
         registro <= '0;
      else if (zeraR)
         registro <= '0;
      else if (registraR)
         registro <= chaves;
   end

   // Expected-value ROM, read asynchronously at the current counter address.
   always_comb begin
      memoria = '0;
      case (int'(contagem))
         0:       memoria = N_DADOS'(1);
         1:       memoria = N_DADOS'(2);
         2:       memoria = N_DADOS'(4);
         3:       memoria = N_DADOS'(8);
         4:       memoria = N_DADOS'(4);
         5:       memoria = N_DADOS'(2);
         6:       memoria = N_DADOS'(1);
         7:       memoria = N_DADOS'(1);
         8:       memoria = N_DADOS'(2);
         9:       memoria = N_DADOS'(2);
         10:      memoria = N_DADOS'(4);
         11:      memoria = N_DADOS'(4);
         12:      memoria = N_DADOS'(8);
         13:      memoria = N_DADOS'(8);
         14:      memoria = N_DADOS'(1);
         15:      memoria = N_DADOS'(4);
         default: memoria = '0;
      endcase
   end

   // Remember whether any switch was on last cycle, for the entry edge detector.
   always_ff @(posedge clock) begin
      if (reset)
         chaves_ant <= 1'b0;
      else
         chaves_ant <= chaves_ativas;
   end

   assign chaves_ativas = |chaves;
   assign jogada_feita  = chaves_ativas & ~chaves_ant;
   assign fimC          = (contagem == {N_END{1'b1}});
   assign resultado     = (registro != memoria);
   assign db_contagem   = contagem;
   assign db_memoria    = memoria;
   assign db_chaves     = registro;

`ifdef FLUXO_TENTATIVAS_EN
   logic [3:0] tentativas;

   // Count register loads, saturating at 15; zeraR clears and wins over a load.
   always_ff @(posedge clock) begin
      if (reset)
         tentativas <= 4'd0;
      else if (zeraR)
         tentativas <= 4'd0;
      else if (registraR && (tentativas != 4'hF))
         tentativas <= tentativas + 4'd1;
   end

   assign db_tentativas = tentativas;
`else
   assign db_tentativas = 4'b0000;
`endif

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Directed testbench for exp3_fluxo_dados.
module tb_exp3_fluxo_dados;

   logic       clock = 1'b0;
   logic       reset, zeraC, contaC, zeraR, registraR;
   logic [3:0] chaves;
   logic       fimC, resultado, jogada_feita;
   logic [3:0] db_contagem, db_memoria, db_chaves, db_tentativas;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] rom_ref [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                                4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

   exp3_fluxo_dados dut (
      .clock         (clock),
      .reset         (reset),
      .zeraC         (zeraC),
      .contaC        (contaC),
      .zeraR         (zeraR),
      .registraR     (registraR),
      .chaves        (chaves),
      .fimC          (fimC),
      .resultado     (resultado),
      .jogada_feita  (jogada_feita),
      .db_contagem   (db_contagem),
      .db_memoria    (db_memoria),
      .db_chaves     (db_chaves),
      .db_tentativas (db_tentativas)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; zeraC = 1'b0; contaC = 1'b0;
      zeraR = 1'b0; registraR = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      chaves = 4'b0000;
      do_reset();
      vectors++;
      if (db_contagem !== 4'd0) begin
         miscompares++; $display("FAIL reset_contagem got %0d want 0", db_contagem);
      end
      vectors++;
      if (db_memoria !== 4'b0001) begin
         miscompares++; $display("FAIL reset_memoria got %b want 0001", db_memoria);
      end
      vectors++;
      if (db_chaves !== 4'b0000) begin
         miscompares++; $display("FAIL reset_chaves got %b want 0000", db_chaves);
      end
      vectors++;
      if (resultado !== 1'b1) begin
         miscompares++; $display("FAIL reset_resultado got %b want 1", resultado);
      end
      vectors++;
      if (fimC !== 1'b0) begin
         miscompares++; $display("FAIL reset_fimC got %b want 0", fimC);
      end
      vectors++;
      if (jogada_feita !== 1'b0) begin
         miscompares++; $display("FAIL reset_jogada got %b want 0", jogada_feita);
      end
      vectors++;
      if (db_tentativas !== 4'd0) begin
         miscompares++; $display("FAIL reset_tentativas got %0d want 0", db_tentativas);
      end
   endtask

   task automatic test_register();
      do_reset();
      chaves = 4'b0001;
      registraR = 1'b1;
      tick();
      registraR = 1'b0;
      vectors++;
      if (db_chaves !== 4'b0001) begin
         miscompares++; $display("FAIL reg_load got %b want 0001", db_chaves);
      end
      vectors++;
      if (resultado !== 1'b0) begin
         miscompares++; $display("FAIL reg_match got %b want 0", resultado);
      end
      contaC = 1'b1;
      tick();
      contaC = 1'b0;
      vectors++;
      if (db_contagem !== 4'd1) begin
         miscompares++; $display("FAIL reg_count got %0d want 1", db_contagem);
      end
      vectors++;
      if (db_memoria !== 4'b0010) begin
         miscompares++; $display("FAIL reg_memoria got %b want 0010", db_memoria);
      end
      vectors++;
      if (resultado !== 1'b1) begin
         miscompares++; $display("FAIL reg_mismatch got %b want 1", resultado);
      end
      vectors++;
      if (db_chaves !== 4'b0001) begin
         miscompares++; $display("FAIL reg_hold got %b want 0001", db_chaves);
      end
      chaves = 4'b0000;
   endtask

   task automatic test_count_wrap();
      do_reset();
      contaC = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         vectors++;
         if (db_contagem !== 4'(k)) begin
            miscompares++; $display("FAIL count_step got %0d want %0d", db_contagem, k);
         end
         vectors++;
         if (db_memoria !== rom_ref[k]) begin
            miscompares++; $display("FAIL rom_addr%0d got %b want %b", k, db_memoria, rom_ref[k]);
         end
         vectors++;
         if (fimC !== (k == 15)) begin
            miscompares++; $display("FAIL fimC_at%0d got %b want %b", k, fimC, (k == 15));
         end
      end
      tick();
      contaC = 1'b0;
      vectors++;
      if (db_contagem !== 4'd0) begin
         miscompares++; $display("FAIL count_wrap got %0d want 0", db_contagem);
      end
      vectors++;
      if (fimC !== 1'b0) begin
         miscompares++; $display("FAIL fimC_wrap got %b want 0", fimC);
      end
   endtask

   task automatic test_priority();
      do_reset();
      contaC = 1'b1;
      repeat (5) tick();
      vectors++;
      if (db_contagem !== 4'd5) begin
         miscompares++; $display("FAIL prio_count5 got %0d want 5", db_contagem);
      end
      zeraC = 1'b1;
      tick();
      zeraC = 1'b0; contaC = 1'b0;
      vectors++;
      if (db_contagem !== 4'd0) begin
         miscompares++; $display("FAIL prio_zeraC got %0d want 0", db_contagem);
      end
      chaves = 4'b1000;
      registraR = 1'b1;
      tick();
      vectors++;
      if (db_chaves !== 4'b1000) begin
         miscompares++; $display("FAIL prio_load got %b want 1000", db_chaves);
      end
      zeraR = 1'b1;
      tick();
      zeraR = 1'b0; registraR = 1'b0;
      vectors++;
      if (db_chaves !== 4'b0000) begin
         miscompares++; $display("FAIL prio_zeraR got %b want 0000", db_chaves);
      end
      registraR = 1'b1;
      tick();
      registraR = 1'b0;
      contaC = 1'b1;
      repeat (7) tick();
      vectors++;
      if (db_contagem !== 4'd7) begin
         miscompares++; $display("FAIL prio_count7 got %0d want 7", db_contagem);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; contaC = 1'b0;
      vectors++;
      if (db_contagem !== 4'd0) begin
         miscompares++; $display("FAIL prio_reset_count got %0d want 0", db_contagem);
      end
      vectors++;
      if (db_chaves !== 4'b0000) begin
         miscompares++; $display("FAIL prio_reset_reg got %b want 0000", db_chaves);
      end
      chaves = 4'b0000;
      tick();
   endtask

   task automatic test_jogada();
      do_reset();
      chaves = 4'b0000;
      tick();
      chaves = 4'b0100;
      #1;
      vectors++;
      if (jogada_feita !== 1'b1) begin
         miscompares++; $display("FAIL jog_rise got %b want 1", jogada_feita);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (jogada_feita !== 1'b0) begin
            miscompares++; $display("FAIL jog_held%0d got %b want 0", k, jogada_feita);
         end
      end
      tick();
      chaves = 4'b1000;
      #1;
      vectors++;
      if (jogada_feita !== 1'b0) begin
         miscompares++; $display("FAIL jog_change got %b want 0", jogada_feita);
      end
      tick();
      chaves = 4'b0000;
      #1;
      vectors++;
      if (jogada_feita !== 1'b0) begin
         miscompares++; $display("FAIL jog_release got %b want 0", jogada_feita);
      end
      tick();
      chaves = 4'b0001;
      #1;
      vectors++;
      if (jogada_feita !== 1'b1) begin
         miscompares++; $display("FAIL jog_rise2 got %b want 1", jogada_feita);
      end
      tick();
      vectors++;
      if (jogada_feita !== 1'b0) begin
         miscompares++; $display("FAIL jog_after2 got %b want 0", jogada_feita);
      end
      chaves = 4'b0000;
   endtask

   task automatic test_tentativas();
      logic [3:0] exp3, exp15;
`ifdef FLUXO_TENTATIVAS_EN
      exp3 = 4'd3; exp15 = 4'd15;
`else
      exp3 = 4'd0; exp15 = 4'd0;
`endif
      do_reset();
      chaves = 4'b0010;
      repeat (3) begin
         registraR = 1'b1; tick();
         registraR = 1'b0; tick();
      end
      vectors++;
      if (db_tentativas !== exp3) begin
         miscompares++; $display("FAIL tent_three got %0d want %0d", db_tentativas, exp3);
      end
      repeat (17) begin
         registraR = 1'b1; tick();
         registraR = 1'b0; tick();
      end
      vectors++;
      if (db_tentativas !== exp15) begin
         miscompares++; $display("FAIL tent_saturate got %0d want %0d", db_tentativas, exp15);
      end
      zeraR = 1'b1;
      tick();
      zeraR = 1'b0;
      vectors++;
      if (db_tentativas !== 4'd0) begin
         miscompares++; $display("FAIL tent_clear got %0d want 0", db_tentativas);
      end
      chaves = 4'b0000;
   endtask

   initial begin
      idle_inputs();
      chaves = 4'b0000;
      test_reset();
      test_register();
      test_count_wrap();
      test_priority();
      test_jogada();
      test_tentativas();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
